// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target register block: FSM state codes,
// bus ACK/NACK levels, out-of-range read value and a pointer range helper.
package i2c_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE    = 4'd0;
    localparam state_t ST_DEVADDR = 4'd1;
    localparam state_t ST_DEVACK  = 4'd2;
    localparam state_t ST_REGPTR  = 4'd3;
    localparam state_t ST_PTRACK  = 4'd4;
    localparam state_t ST_WDATA   = 4'd5;
    localparam state_t ST_WDACK   = 4'd6;
    localparam state_t ST_RDATA   = 4'd7;
    localparam state_t ST_RDACK   = 4'd8;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam logic [7:0] RD_OOR_VAL = 8'hFF;

    function automatic logic in_range(input logic [7:0] idx, input int depth);
        return int'(idx) < depth;
    endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// Conditions one asynchronous I2C line: 2-flop synchronizer, optional 4-sample
// stability filter (I2C_GLITCH_FILTER_EN), and rise/fall detection.
module i2c_line_cond (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync;
    logic       prev;

    // Reset to 1 so an idle bus produces no edge when reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
        end else begin
            // NOTE: non-blocking assignment keeps this a true two-stage shift.
            sync <= {sync[0], line};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] diff_cnt;
    logic       filt;

    // Output follows only after four consecutive samples disagree with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt     <= 1'b1;
            diff_cnt <= 2'd0;
        end else if (sync[1] == filt) begin
            diff_cnt <= 2'd0;
        end else if (diff_cnt == 2'd3) begin
            filt     <= sync[1];
            diff_cnt <= 2'd0;
        end else begin
            diff_cnt <= diff_cnt + 2'd1;
        end
    end

    assign level = filt;
`else
    assign level = sync[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b1;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with an 8-bit register file, write strobe and host read port.
// Build option: I2C_GLITCH_FILTER_EN adds a 4-cycle stability filter on SCL/SDA.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h3C,
    parameter int         DEPTH    = 16,
    parameter logic [7:0] RST_VAL  = 8'h00
) (
    input  logic                     CLK_50,
    input  logic                     RESET_N,
    input  logic                     SCL_IN,
    input  logic                     SDA_IN,
    output logic                     SDA_OE,
    output logic                     BUSY,
    output logic                     REG_WR_STB,
    output logic [7:0]               REG_WR_ADDR,
    output logic [7:0]               REG_WR_DATA,
    input  logic [$clog2(DEPTH)-1:0] HOST_RADDR,
    output logic [7:0]               HOST_RDATA
);

    localparam int AW = $clog2(DEPTH);

    logic       scl, scl_rise, scl_fall;
    logic       sda, sda_rise, sda_fall;
    logic       start_cond, stop_cond;
    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] shift, ptr, ptr_next, rx_byte, rd_cur, rd_nxt;
    logic       ack_drv, ack_ok, rd_first, wr_en;
    logic [7:0] regs [DEPTH];

    i2c_line_cond u_scl (.clk(CLK_50), .rst_n(RESET_N), .line(SCL_IN),
                         .level(scl), .rise(scl_rise), .fall(scl_fall));
    i2c_line_cond u_sda (.clk(CLK_50), .rst_n(RESET_N), .line(SDA_IN),
                         .level(sda), .rise(sda_rise), .fall(sda_fall));

    assign start_cond = scl & sda_fall;
    assign stop_cond  = scl & sda_rise;
    assign rx_byte    = {shift[6:0], sda};
    assign ptr_next   = ptr + 8'd1;
    assign rd_cur     = in_range(ptr, DEPTH)      ? regs[ptr[AW-1:0]]      : RD_OOR_VAL;
    assign rd_nxt     = in_range(ptr_next, DEPTH) ? regs[ptr_next[AW-1:0]] : RD_OOR_VAL;
    assign HOST_RDATA = regs[HOST_RADDR];

    // A data byte commits only on its 8th SCL rise, so aborted bytes never land.
    assign wr_en = !start_cond && !stop_cond && (state == ST_WDATA) && scl_rise
                   && (bit_cnt == 4'd7) && in_range(ptr, DEPTH);

    // NOTE: the register file is reset explicitly, so it maps to flops rather than RAM.
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= RST_VAL;
        end else if (wr_en) begin
            regs[ptr[AW-1:0]] <= rx_byte;
        end
    end

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= ST_IDLE;
            bit_cnt     <= 4'd0;
            shift       <= 8'd0;
            ptr         <= 8'd0;
            SDA_OE      <= 1'b0;
            BUSY        <= 1'b0;
            REG_WR_STB  <= 1'b0;
            REG_WR_ADDR <= 8'd0;
            REG_WR_DATA <= 8'd0;
            ack_drv     <= 1'b0;
            ack_ok      <= 1'b0;
            rd_first    <= 1'b0;
        end else begin
            REG_WR_STB <= 1'b0;
            if (stop_cond) begin
                state   <= ST_IDLE;
                SDA_OE  <= 1'b0;
                BUSY    <= 1'b0;
                ack_drv <= 1'b0;
            end else if (start_cond) begin
                state   <= ST_DEVADDR;
                bit_cnt <= 4'd0;
                ack_drv <= 1'b0;
            end else begin
                case (state)
                    ST_DEVADDR, ST_REGPTR, ST_WDATA: begin
                        if (scl_fall) SDA_OE <= 1'b0;
                        if (scl_rise) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd0;
                                if (state == ST_DEVADDR) begin
                                    if (rx_byte[7:1] == DEV_ADDR) begin
                                        state <= ST_DEVACK;
                                        BUSY  <= 1'b1;
                                    end else begin
                                        state <= ST_IDLE;
                                    end
                                end else if (state == ST_REGPTR) begin
                                    ptr   <= rx_byte;
                                    state <= ST_PTRACK;
                                end else begin
                                    ack_ok      <= in_range(ptr, DEPTH);
                                    REG_WR_STB  <= in_range(ptr, DEPTH);
                                    REG_WR_ADDR <= ptr;
                                    REG_WR_DATA <= rx_byte;
                                    ptr         <= ptr_next;
                                    state       <= ST_WDACK;
                                end
                            end
                        end
                    end
                    ST_DEVACK, ST_PTRACK, ST_WDACK: begin
                        if (scl_fall) begin
                            if (!ack_drv) begin
                                ack_drv <= 1'b1;
                                SDA_OE  <= (state == ST_WDACK) ? ack_ok : 1'b1;
                            end else begin
                                ack_drv <= 1'b0;
                                SDA_OE  <= 1'b0;
                                if (state == ST_DEVACK && shift[0]) begin
                                    shift    <= rd_cur;
                                    SDA_OE   <= ~rd_cur[7];
                                    bit_cnt  <= 4'd0;
                                    rd_first <= 1'b0;
                                    state    <= ST_RDATA;
                                end else if (state == ST_DEVACK) begin
                                    state <= ST_REGPTR;
                                end else begin
                                    state <= ST_WDATA;
                                end
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
                        if (scl_fall) begin
                            if (rd_first) begin
                                SDA_OE   <= ~shift[7];
                                rd_first <= 1'b0;
                            end else if (bit_cnt == 4'd8) begin
                                SDA_OE  <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= ST_RDACK;
                            end else begin
                                SDA_OE <= ~shift[6];
                                shift  <= {shift[6:0], 1'b0};
                            end
                        end
                    end
                    ST_RDACK: begin
                        if (scl_rise) begin
                            if (sda == I2C_ACK) begin
                                ptr      <= ptr_next;
                                shift    <= rd_nxt;
                                rd_first <= 1'b1;
                                bit_cnt  <= 4'd0;
                                state    <= ST_RDATA;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
